uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Byte queue that sits directly upstream of the UART transmitter. It presents a head byte on data_o with data_rdy, and pops that byte on the transmitter's one-cycle fetch pulse. Producers (CPU bus, packet formatter) write bytes with a single-cycle strobe. It shares the transmitter's clock, so no clock-domain crossing is needed.

Parameters:
DEPTH_LOG2, 4, log2 of queue depth; depth = 2**DEPTH_LOG2 (default 16 bytes); legal range 1..10.

Ports:
clk  input  1  shared with the UART transmitter; all logic on posedge.
rst  input  1  synchronous, active-high reset.
wr  input  1  write strobe; data_i is enqueued at a posedge where wr=1 and the write is accepted.
data_i  input  8  byte to enqueue.
full  output  1  high when count == depth.
count  output  DEPTH_LOG2+1  number of stored bytes, 0..depth.
data_o  output  8  head byte; wire to the transmitter's data input.
data_rdy  output  1  high when count > 0; wire to the transmitter's data_rdy.
fetch  input  1  pop pulse from the transmitter; one pop per posedge with fetch=1 and count>0.
ovf  output  1  only with UART_TX_FIFO_OVF_EN; sticky overflow flag.
ovf_clr  input  1  only with UART_TX_FIFO_OVF_EN; clears ovf.

Behaviour:
- Reset values: count=0, full=0, data_rdy=0, data_o=8'h00, rd/wr pointers=0, ovf=0. Memory contents are not reset.
- Reset mid-operation:
  - Queue is emptied on the next posedge.
  - A byte already latched by the transmitter finishes transmitting; it is not this block's concern.
  - rst has priority over wr, fetch and ovf_clr.
- Storage: circular buffer, DEPTH_LOG2-bit pointers that wrap naturally from depth-1 to 0; count is a separate register.
- data_o is a registered head:
  - Write to an empty queue: data_o = data_i and data_rdy=1 on the following cycle (latency 1).
  - Pop with count >= 2: data_o = next entry on the following cycle.
  - Pop with count == 1: data_rdy=0 next cycle; data_o holds the last value.
- Write acceptance: accepted if !full, or if full and fetch=1 in the same cycle (pass-through on full).
- Rejected write (full, no fetch): byte dropped, no state change.
- Pop: fetch=1 with count>0 advances rd_ptr. fetch=1 with count==0 is ignored.
- Simultaneous write and pop:
  - count>0: count unchanged, both pointers advance.
  - count==0: fetch is ignored, the write is accepted, count becomes 1.
- full and data_rdy are registered, consistent with count in the same cycle.
- Transmitter contract:
  - fetch is high for exactly one cycle per byte.
  - The transmitter samples data_o on the same edge it raises fetch.
  - The next fetch comes at least 10 cycles later, so no head-refresh hazard exists.
  - The block still tolerates back-to-back fetch pulses correctly.

Optional Feature:
UART_TX_FIFO_OVF_EN:
- Defined: ports ovf and ovf_clr exist. ovf is set on the posedge after a rejected write and stays high until ovf_clr=1 or rst. If set and clear occur in the same cycle, set wins.
- Undefined: both ports are absent and rejected writes are silently dropped.

Decomposition:
- Shared include header uart_defs.vh: UART_DATA_W = 8, also used by the UART transmitter and receiver.
- One natural sub-module, sdp_ram: simple dual-port array with one write port and one synchronous-read port, parameterized by width and address bits. It may map to iCE40 EBR for DEPTH_LOG2 >= 8.
- Pointer, count and head logic stay in uart_tx_fifo.

Test Plan:
- Reset, then write 8'hA5 → next cycle data_o=8'hA5, data_rdy=1, count=1; one fetch pulse → data_rdy=0, count=0.
- DEPTH_LOG2=4: write 8'h00..8'h0F → full=1, count=16. A 17th write (8'hFF) without fetch is dropped; with the feature enabled, ovf=1. Pop all 16 → bytes 0x00..0x0F in order.
- Full queue, wr=1 with data_i=8'h77 and fetch=1 in the same cycle → count stays 16, and 8'h77 emerges as the 16th pop.
- Empty queue, wr=1 with data_i=8'h3C and fetch=1 together → count=1, data_o=8'h3C; fetch on empty alone leaves count=0.
- Wrap-around: 40 interleaved writes and pops with occupancy 3..7 → output sequence matches a scoreboard through multiple pointer wraps.
- Connected to the real UART transmitter: enqueue "Hi\n" (0x48, 0x69, 0x0A) → serial line shows three 8n1 frames LSB-first, and data_rdy drops after the third fetch. Assert rst mid-frame → count=0 next cycle.

Source files
------------

// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit byte queue.
// Holds the UART character width and the head-source selector type.
package uart_tx_fifo_pkg;

    localparam int UART_DATA_W = 8;

    // Where the registered head byte currently comes from.
    typedef enum logic {
        HEAD_BYPASS = 1'b0,
        HEAD_RAM    = 1'b1
    } head_src_e;

    // Even parity over one character, available to storage checkers.
    function automatic logic char_parity(input logic [UART_DATA_W-1:0] ch);
        return ^ch;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_sdp_ram.sv
// sdp_ram: simple dual-port array, one write port and one synchronous read port.
// Plain array with no reset so it can map onto block RAM for deep configurations.
module sdp_ram #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_r [0:(1<<ADDR_W)-1];
    logic [WIDTH-1:0] rdata_r;

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Synchronous read port; output holds when not enabled.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte queue feeding the UART transmitter with a registered head byte.
// Optional sticky overflow flag (ports ovf/ovf_clr) enabled by UART_TX_FIFO_OVF_EN.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr,
    input  logic [UART_DATA_W-1:0] data_i,
    output logic                   full,
    output logic [DEPTH_LOG2:0]    count,
    output logic [UART_DATA_W-1:0] data_o,
    output logic                   data_rdy,
    input  logic                   fetch
`ifdef UART_TX_FIFO_OVF_EN
    ,
    output logic                   ovf,
    input  logic                   ovf_clr
`endif
);

    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DEPTH_LOG2-1:0]  wr_ptr_r;
    logic [DEPTH_LOG2-1:0]  rd_ptr_r;
    logic [CW-1:0]          count_r;
    logic                   full_r;
    logic                   rdy_r;
    logic [UART_DATA_W-1:0] byp_r;
    head_src_e              head_src_r;

    logic                   empty_s;
    logic                   pop_s;
    logic                   acc_s;
    logic                   ram_re_s;
    logic                   load_byp_s;
    logic [CW-1:0]          count_nxt_s;
    logic [DEPTH_LOG2-1:0]  rd_next_s;
    logic [UART_DATA_W-1:0] ram_rdata_s;
    logic [UART_DATA_W-1:0] head_s;

    // Accept/pop decisions; a write on a full queue is taken only alongside a pop.
    always_comb begin
        empty_s    = (count_r == {CW{1'b0}});
        pop_s      = fetch & ~empty_s;
        acc_s      = wr & (~full_r | fetch);
        rd_next_s  = rd_ptr_r + DEPTH_LOG2'(1'b1);
        ram_re_s   = pop_s & (count_r >= CW'(2'd2));
        load_byp_s = acc_s & (empty_s | (pop_s & (count_r == CW'(1'b1))));
        case ({acc_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1'b1);
            2'b01:   count_nxt_s = count_r - CW'(1'b1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer, occupancy and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r <= {DEPTH_LOG2{1'b0}};
            count_r  <= {CW{1'b0}};
            full_r   <= 1'b0;
            rdy_r    <= 1'b0;
        end else begin
            if (acc_s) begin
                wr_ptr_r <= wr_ptr_r + DEPTH_LOG2'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_next_s;
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CW'(DEPTH));
            rdy_r   <= (count_nxt_s != {CW{1'b0}});
        end
    end

    // Head source: a byte entering as the sole entry bypasses the array,
    // otherwise the array read of the following slot supplies the new head.
    always_ff @(posedge clk) begin
        if (rst) begin
            byp_r      <= {UART_DATA_W{1'b0}};
            head_src_r <= HEAD_BYPASS;
        end else if (load_byp_s) begin
            byp_r      <= data_i;
            head_src_r <= HEAD_BYPASS;
        end else if (ram_re_s) begin
            head_src_r <= HEAD_RAM;
        end
    end

    sdp_ram #(
        .WIDTH  (UART_DATA_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (acc_s),
        .waddr (wr_ptr_r),
        .wdata (data_i),
        .re    (ram_re_s),
        .raddr (rd_next_s),
        .rdata (ram_rdata_s)
    );

    // Head mux between two registered sources.
    always_comb begin
        head_s = byp_r;
        case (head_src_r)
            HEAD_BYPASS: head_s = byp_r;
            HEAD_RAM:    head_s = ram_rdata_s;
            default:     head_s = byp_r;
        endcase
    end

    assign data_o   = head_s;
    assign count    = count_r;
    assign full     = full_r;
    assign data_rdy = rdy_r;

`ifdef UART_TX_FIFO_OVF_EN
    logic ovf_r;

    // Sticky overflow: set on a dropped write, set beats clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (wr & full_r & ~fetch) begin
            ovf_r <= 1'b1;
        end else if (ovf_clr) begin
            ovf_r <= 1'b0;
        end
    end

    assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based model compared every cycle,
// plus directed vectors with literal expectations.
module tb_uart_tx_fifo;

    localparam int DL2   = 4;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr;
    logic [7:0] data_i;
    logic       fetch;
    logic       full;
    logic [4:0] count;
    logic [7:0] data_o;
    logic       data_rdy;
`ifdef UART_TX_FIFO_OVF_EN
    logic       ovf;
    logic       ovf_clr = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_fifo #(.DEPTH_LOG2(DL2)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr       (wr),
        .data_i   (data_i),
        .full     (full),
        .count    (count),
        .data_o   (data_o),
        .data_rdy (data_rdy),
        .fetch    (fetch)
`ifdef UART_TX_FIFO_OVF_EN
        ,
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a byte queue plus the last head shown.
    byte unsigned mq[$];
    byte unsigned m_last = 8'h00;
    bit           m_ovf = 1'b0;
    bit           started = 1'b0;

    always @(posedge clk) begin
        bit do_pop, do_acc, is_full;
        started = 1'b1;
        if (rst) begin
            mq.delete();
            m_last = 8'h00;
            m_ovf  = 1'b0;
        end else begin
            is_full = (mq.size() == DEPTH);
            do_pop  = fetch && (mq.size() > 0);
            do_acc  = wr && (!is_full || fetch);
`ifdef UART_TX_FIFO_OVF_EN
            if (wr && is_full && !fetch) m_ovf = 1'b1;
            else if (ovf_clr)            m_ovf = 1'b0;
`endif
            if (do_pop) void'(mq.pop_front());
            if (do_acc) mq.push_back(data_i);
            if (mq.size() > 0) m_last = mq[0];
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("count",    int'(count),    mq.size());
            check("full",     int'(full),     int'(mq.size() == DEPTH));
            check("data_rdy", int'(data_rdy), int'(mq.size() > 0));
            check("data_o",   int'(data_o),   int'(m_last));
`ifdef UART_TX_FIFO_OVF_EN
            check("ovf",      int'(ovf),      int'(m_ovf));
`endif
        end
    end

    // One clock of stimulus; seen = the head the transmitter samples at this edge.
    task automatic cycle(input logic w, input logic [7:0] d, input logic f,
                         output logic [7:0] seen);
        wr = w; data_i = d; fetch = f;
        seen = data_o;
        @(posedge clk);
        #1;
        wr = 1'b0; fetch = 1'b0;
    endtask

    initial begin
        logic [7:0] seen;
        byte unsigned sb[$];
        int occ;
        logic [7:0] hi [3];
        hi[0] = 8'h48; hi[1] = 8'h69; hi[2] = 8'h0A;

        rst = 1'b1; wr = 1'b0; fetch = 1'b0; data_i = 8'h00;
        cycle(1'b0, 8'h00, 1'b0, seen);
        cycle(1'b0, 8'h00, 1'b0, seen);
        rst = 1'b0;
        check("rst_count", int'(count), 0);
        check("rst_rdy",   int'(data_rdy), 0);
        check("rst_full",  int'(full), 0);
        check("rst_data",  int'(data_o), 8'h00);

        // single byte through
        cycle(1'b1, 8'hA5, 1'b0, seen);
        check("a5_data", int'(data_o), 8'hA5);
        check("a5_rdy",  int'(data_rdy), 1);
        check("a5_cnt",  int'(count), 1);
        cycle(1'b0, 8'h00, 1'b1, seen);
        check("a5_seen", int'(seen), 8'hA5);
        check("a5_rdy0", int'(data_rdy), 0);
        check("a5_hold", int'(data_o), 8'hA5);

        // fill, overflow, drain in order
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, seen);
        check("fill_full", int'(full), 1);
        check("fill_cnt",  int'(count), 16);
        cycle(1'b1, 8'hFF, 1'b0, seen);
        check("drop_cnt", int'(count), 16);
`ifdef UART_TX_FIFO_OVF_EN
        check("ovf_set", int'(ovf), 1);
        ovf_clr = 1'b1;
        cycle(1'b1, 8'hEE, 1'b0, seen);
        check("ovf_setwins", int'(ovf), 1);
        cycle(1'b0, 8'h00, 1'b0, seen);
        ovf_clr = 1'b0;
        check("ovf_clr", int'(ovf), 0);
`endif
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 8'h00, 1'b1, seen);
            check("drain_order", int'(seen), i);
        end
        check("drain_cnt", int'(count), 0);

        // pass-through write on full
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, seen);
        cycle(1'b1, 8'h77, 1'b1, seen);
        check("pt_seen", int'(seen), 8'h10);
        check("pt_cnt",  int'(count), 16);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 8'h00, 1'b1, seen);
            check("pt_order", int'(seen), (i < 15) ? (8'h11 + i) : 8'h77);
        end

        // write+fetch on empty, then fetch on empty
        cycle(1'b1, 8'h3C, 1'b1, seen);
        check("e_cnt",  int'(count), 1);
        check("e_data", int'(data_o), 8'h3C);
        cycle(1'b0, 8'h00, 1'b1, seen);
        check("e_seen", int'(seen), 8'h3C);
        cycle(1'b0, 8'h00, 1'b1, seen);
        check("e_idle_cnt", int'(count), 0);

        // wrap-around with occupancy 3..7
        occ = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 8'(8'h80 + i), 1'b0, seen);
            sb.push_back(8'(8'h80 + i)); occ++;
        end
        for (int k = 0; k < 40; k++) begin
            logic w, f;
            int r;
            r = $urandom_range(0, 2);
            w = (occ <= 3) || (r != 1);
            f = (occ >= 7) || (r != 0);
            if (occ <= 3) f = 1'b0;
            if (occ >= 7) w = 1'b0;
            cycle(w, 8'(8'h40 + k), f, seen);
            if (f) begin
                check("wrap_order", int'(seen), int'(sb.pop_front()));
                occ--;
            end
            if (w) begin
                sb.push_back(8'(8'h40 + k)); occ++;
            end
        end
        while (sb.size() > 0) begin
            cycle(1'b0, 8'h00, 1'b1, seen);
            check("wrap_drain", int'(seen), int'(sb.pop_front()));
        end

        // transmitter-style spacing: "Hi\n"
        for (int i = 0; i < 3; i++) cycle(1'b1, hi[i], 1'b0, seen);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'h00, 1'b1, seen);
            check("hi_byte", int'(seen), int'(hi[i]));
            for (int j = 0; j < 9; j++) cycle(1'b0, 8'h00, 1'b0, seen);
        end
        check("hi_rdy0", int'(data_rdy), 0);

        // reset mid-operation
        cycle(1'b1, 8'h55, 1'b0, seen);
        cycle(1'b1, 8'h66, 1'b0, seen);
        cycle(1'b0, 8'h00, 1'b1, seen);
        rst = 1'b1;
        cycle(1'b1, 8'h99, 1'b1, seen);
        rst = 1'b0;
        check("mid_rst_cnt",  int'(count), 0);
        check("mid_rst_rdy",  int'(data_rdy), 0);
        check("mid_rst_data", int'(data_o), 8'h00);
        cycle(1'b0, 8'h00, 1'b0, seen);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
